// File: rtl/mem_pkg.sv
// Shared definitions for param_memory: the sequencer state encoding, the
// byte-lane width of the default word, and the address range check that
// both the write path and every read port rely on.
package mem_pkg;

    // Default word width of the memory and its number of byte lanes.
    localparam int unsigned DATA_W_DFLT = 32;
    localparam int unsigned BE_W        = DATA_W_DFLT / 8;

    // Sequencer states: normal access, clear sweep, dump stream.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DUMP  = 2'd2
    } seq_state_e;

    // True when an address falls inside the populated part of the array.
    function automatic logic adr_in_range(input logic [31:0] adr, input int unsigned depth);
        return adr < depth;
    endfunction

endpackage

// File: rtl/mem_seq_ctrl.sv
// Clear/dump sequencer for param_memory.
// Owns the state machine, the shared sweep pointer, busy and the dump
// valid/ready handshake outputs.
//   clk, rst_n      clock, asynchronous active-low reset
//   i_clr_start     pulse: start zeroing the array (wins over dump start)
//   i_dump_start    pulse: start streaming the array
//   i_dump_ready    consumer accepts the current dump word
//   o_busy          a clear or dump sequence is in progress
//   o_clr_we        write zero to address o_ptr at the next edge
//   o_wr_ok_c       user writes may be committed at the next edge
//   o_dump_valid    dump word at o_ptr is valid
//   o_dump_last     current dump word is the final address
//   o_ptr           sweep pointer (clear target / dump address)
module mem_seq_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH = 128,
    parameter int unsigned ADR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr_start,
    input  logic             i_dump_start,
    input  logic             i_dump_ready,
    output logic             o_busy,
    output logic             o_clr_we,
    output logic             o_wr_ok_c,
    output logic             o_dump_valid,
    output logic             o_dump_last,
    output logic [ADR_W-1:0] o_ptr
);

    // Terminal pointer value; compared explicitly so non-power-of-two depths work.
    localparam logic [ADR_W-1:0] LAST_PTR = ADR_W'(DEPTH - 1);

    seq_state_e       r_state;
    seq_state_e       w_state_nxt;
    logic [ADR_W-1:0] r_ptr;
    logic [ADR_W-1:0] w_ptr_nxt;
    logic             r_busy;
    logic             r_clr_we;
    logic             r_dump_valid;
    logic             r_dump_last;
    logic             w_busy_nxt;
    logic             w_clr_we_nxt;
    logic             w_dump_valid_nxt;
    logic             w_dump_last_nxt;

    // State, pointer and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_ptr        <= '0;
            r_busy       <= 1'b0;
            r_clr_we     <= 1'b0;
            r_dump_valid <= 1'b0;
            r_dump_last  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_ptr        <= w_ptr_nxt;
            r_busy       <= w_busy_nxt;
            r_clr_we     <= w_clr_we_nxt;
            r_dump_valid <= w_dump_valid_nxt;
            r_dump_last  <= w_dump_last_nxt;
        end
    end

    // Next-state, pointer advance and next values of the registered outputs.
    always_comb begin
        w_state_nxt      = r_state;
        w_ptr_nxt        = r_ptr;
        w_busy_nxt       = 1'b0;
        w_clr_we_nxt     = 1'b0;
        w_dump_valid_nxt = 1'b0;
        w_dump_last_nxt  = 1'b0;
        o_wr_ok_c        = 1'b0;

        unique case (r_state)
            IDLE: begin
                // A start accepted on this edge also blocks the user write on it.
                o_wr_ok_c = !i_clr_start && !i_dump_start;
                if (i_clr_start) begin
                    w_state_nxt = CLEAR;
                    w_ptr_nxt   = '0;
                end else if (i_dump_start) begin
                    w_state_nxt = DUMP;
                    w_ptr_nxt   = '0;
                end
            end
            CLEAR: begin
                if (r_ptr == LAST_PTR) begin
                    w_state_nxt = IDLE;
                    w_ptr_nxt   = '0;
                end else begin
                    w_ptr_nxt = r_ptr + ADR_W'(1);
                end
            end
            DUMP: begin
                if (i_dump_ready) begin
                    if (r_ptr == LAST_PTR) begin
                        w_state_nxt = IDLE;
                        w_ptr_nxt   = '0;
                    end else begin
                        w_ptr_nxt = r_ptr + ADR_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_ptr_nxt   = '0;
            end
        endcase

        w_busy_nxt       = (w_state_nxt != IDLE);
        w_clr_we_nxt     = (w_state_nxt == CLEAR);
        w_dump_valid_nxt = (w_state_nxt == DUMP);
        w_dump_last_nxt  = (w_state_nxt == DUMP) && (w_ptr_nxt == LAST_PTR);
    end

    assign o_busy       = r_busy;
    assign o_clr_we     = r_clr_we;
    assign o_dump_valid = r_dump_valid;
    assign o_dump_last  = r_dump_last;
    assign o_ptr        = r_ptr;

endmodule

// File: rtl/param_memory.sv
// Parametrised word memory: byte-enabled synchronous write port, NUM_RD
// independent read ports (combinational or one-cycle registered), and a
// clear/dump sequencer for draining or wiping the array.
//   clk, rst_n                    clock, asynchronous active-low reset
//   wr_en/wr_adr/wr_data/wr_be    write port, byte lane i = bits 8i+7:8i
//   rd_adr/rd_data                read port k in slice k; out of range reads 0
//   clr_start/dump_start          sequence start pulses, honoured only when idle
//   busy                          clear or dump in progress (writes dropped)
//   dump_valid/ready/data/adr/last  dump stream handshake
module param_memory
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W    = DATA_W_DFLT,
    parameter int unsigned DEPTH     = 128,
    parameter int unsigned ADR_W     = 8,
    parameter int unsigned NUM_RD    = 2,
    parameter bit          REG_RD    = 1'b0,
    parameter string       INIT_FILE = ""
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [ADR_W-1:0]         wr_adr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [DATA_W/8-1:0]      wr_be,
    input  logic [NUM_RD*ADR_W-1:0]  rd_adr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     clr_start,
    input  logic                     dump_start,
    output logic                     busy,
    output logic                     dump_valid,
    input  logic                     dump_ready,
    output logic [DATA_W-1:0]        dump_data,
    output logic [ADR_W-1:0]         dump_adr,
    output logic                     dump_last
);

    localparam int unsigned NBE   = DATA_W / 8;
    // Index width of the storage array itself (may be narrower than ADR_W).
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0]        r_mem [DEPTH];
    logic                     w_clr_we;
    logic                     w_wr_ok_c;
    logic                     w_wr_fire;
    logic [ADR_W-1:0]         w_ptr;
    logic [NUM_RD*DATA_W-1:0] w_rd_data;

    mem_seq_ctrl #(
        .DEPTH (DEPTH),
        .ADR_W (ADR_W)
    ) u_seq (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clr_start  (clr_start),
        .i_dump_start (dump_start),
        .i_dump_ready (dump_ready),
        .o_busy       (busy),
        .o_clr_we     (w_clr_we),
        .o_wr_ok_c    (w_wr_ok_c),
        .o_dump_valid (dump_valid),
        .o_dump_last  (dump_last),
        .o_ptr        (w_ptr)
    );

    assign w_wr_fire = wr_en && w_wr_ok_c && adr_in_range(32'(wr_adr), DEPTH);

    // Array update: clear sweep or byte-merged user write. Not reset, so
    // contents survive rst_n.
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[IDX_W'(w_ptr)] <= '0;
        end else if (w_wr_fire) begin
            for (int b = 0; b < NBE; b++) begin
                if (wr_be[b]) begin
                    r_mem[IDX_W'(wr_adr)][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // Independent read ports; addresses beyond the array return zero.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADR_W-1:0] w_adr;
        assign w_adr = rd_adr[k*ADR_W +: ADR_W];
        assign w_rd_data[k*DATA_W +: DATA_W] =
            adr_in_range(32'(w_adr), DEPTH) ? r_mem[IDX_W'(w_adr)] : '0;
    end

    // Registered mode samples the pre-write contents, giving read-first data.
    if (REG_RD) begin : g_rd_reg
        logic [NUM_RD*DATA_W-1:0] r_rd_data;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_rd_data <= '0;
            end else begin
                r_rd_data <= w_rd_data;
            end
        end
        assign rd_data = r_rd_data;
    end else begin : g_rd_comb
        assign rd_data = w_rd_data;
    end

    // Dump stream: the pointer only moves on a handshake, so data is stable
    // while stalled, and writes are blocked while the stream is active.
    assign dump_data = r_mem[IDX_W'(w_ptr)];
    assign dump_adr  = w_ptr;

endmodule

// File: tb/tb_param_memory.sv
module tb_param_memory;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en, wr_en1;
    logic [7:0]  wr_adr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic [15:0] rd_adr;
    logic        clr_start, dump_start, dump_ready;
    logic [63:0] rd_data0, rd_data1;
    logic        busy0, busy1, dv0, dv1, dl0, dl1;
    logic [31:0] dd0, dd1;
    logic [7:0]  da0, da1;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference contents: dut0 has 128 words, dut1 has 100 words.
    logic [31:0] m0 [128];
    logic [31:0] m1 [100];
    logic [31:0] e1q0, e1q1;

    typedef struct {
        logic        we;
        logic [7:0]  wa;
        logic [31:0] wd;
        logic [3:0]  be;
        logic [7:0]  a0;
        logic [7:0]  a1;
        logic [31:0] e0a;
        logic [31:0] e0b;
        logic [31:0] e1a;
        logic [31:0] e1b;
    } vec_t;

    vec_t tbl [8];

    param_memory #(.DEPTH(128), .REG_RD(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_adr(wr_adr), .wr_data(wr_data),
        .wr_be(wr_be), .rd_adr(rd_adr), .rd_data(rd_data0), .clr_start(clr_start),
        .dump_start(dump_start), .busy(busy0), .dump_valid(dv0), .dump_ready(dump_ready),
        .dump_data(dd0), .dump_adr(da0), .dump_last(dl0)
    );

    param_memory #(.DEPTH(100), .REG_RD(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en1), .wr_adr(wr_adr), .wr_data(wr_data),
        .wr_be(wr_be), .rd_adr(rd_adr), .rd_data(rd_data1), .clr_start(clr_start),
        .dump_start(1'b0), .busy(busy1), .dump_valid(dv1), .dump_ready(1'b1),
        .dump_data(dd1), .dump_adr(da1), .dump_last(dl1)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mrd0(input int a);
        return (a < 128) ? m0[a] : 32'h0;
    endfunction

    function automatic logic [31:0] mrd1(input int a);
        return (a < 100) ? m1[a] : 32'h0;
    endfunction

    task automatic mwr(input logic en0, input logic en1, input int a,
                       input logic [31:0] d, input logic [3:0] be);
        logic [31:0] mask;
        for (int b = 0; b < 4; b++) mask[8*b +: 8] = {8{be[b]}};
        if (en0 && a < 128) m0[a] = (m0[a] & ~mask) | (d & mask);
        if (en1 && a < 100) m1[a] = (m1[a] & ~mask) | (d & mask);
    endtask

    // One access cycle, entered and left at posedge+1.
    task automatic rw_cycle(input logic we, input logic we1, input logic [7:0] wa,
                            input logic [31:0] wd, input logic [3:0] wbe,
                            input logic [7:0] a0, input logic [7:0] a1, input bit use_exp,
                            input logic [31:0] e0a, input logic [31:0] e0b,
                            input logic [31:0] e1a, input logic [31:0] e1b, input string tag);
        wr_en = we; wr_en1 = we1; wr_adr = wa; wr_data = wd; wr_be = wbe;
        rd_adr = {a1, a0};
        @(negedge clk);
        if (!use_exp) begin
            e0a = mrd0(int'(a0)); e0b = mrd0(int'(a1));
            e1a = e1q0;           e1b = e1q1;
        end
        check({tag, " comb p0"}, 64'(rd_data0[31:0]),  64'(e0a));
        check({tag, " comb p1"}, 64'(rd_data0[63:32]), 64'(e0b));
        check({tag, " reg p0"},  64'(rd_data1[31:0]),  64'(e1a));
        check({tag, " reg p1"},  64'(rd_data1[63:32]), 64'(e1b));
        e1q0 = mrd1(int'(a0));
        e1q1 = mrd1(int'(a1));
        mwr(we, we1, int'(wa), wd, wbe);
        @(posedge clk); #1;
    endtask

    // Clear sequence; counts busy cycles of both DUTs. Entered/left at posedge+1.
    task automatic clear_run(input logic with_dump, input logic with_wr, output int c0, output int c1);
        c0 = 0; c1 = 0;
        wr_en = with_wr; wr_en1 = 1'b0; wr_be = 4'hF;
        wr_adr = 8'($urandom_range(0, 127)); wr_data = $urandom;
        clr_start = 1'b1; dump_start = with_dump;
        @(negedge clk);
        check("clear busy before start", 64'(busy0), 64'(0));
        @(posedge clk); #1;
        clr_start = 1'b0; dump_start = 1'b0;
        for (int i = 0; i < 400; i++) begin
            wr_adr = 8'($urandom_range(0, 127)); wr_data = $urandom;
            @(negedge clk);
            if (busy0) begin
                c0++;
                check("no dump valid during clear", 64'(dv0), 64'(0));
            end
            if (busy1) c1++;
            if (!busy0 && !busy1) break;
            @(posedge clk); #1;
        end
        wr_en = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 128; i++) m0[i] = '0;
        for (int i = 0; i < 100; i++) m1[i] = '0;
        e1q0 = '0; e1q1 = '0;
    endtask

    initial begin
        int c0, c1, k, n;
        logic [7:0] a0, a1, wa;

        rst_n = 1'b0; wr_en = 1'b0; wr_en1 = 1'b0; wr_adr = '0; wr_data = '0; wr_be = '0;
        rd_adr = '0; clr_start = 1'b0; dump_start = 1'b0; dump_ready = 1'b0;
        for (int i = 0; i < 128; i++) m0[i] = '0;
        for (int i = 0; i < 100; i++) m1[i] = '0;
        e1q0 = '0; e1q1 = '0;

        tbl[0] = '{1'b1, 8'd5,   32'h11223344, 4'hF,    8'd5,   8'd127, 32'h0,        32'h0,        32'h0,        32'h0};
        tbl[1] = '{1'b1, 8'd5,   32'hAABBCCDD, 4'b0101, 8'd5,   8'd127, 32'h11223344, 32'h0,        32'h0,        32'h0};
        tbl[2] = '{1'b0, 8'd0,   32'h0,        4'h0,    8'd5,   8'd5,   32'h11BB33DD, 32'h11BB33DD, 32'h11223344, 32'h0};
        tbl[3] = '{1'b1, 8'd127, 32'hDEADBEEF, 4'hF,    8'd127, 8'd5,   32'h0,        32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD};
        tbl[4] = '{1'b1, 8'd100, 32'hCAFEF00D, 4'hF,    8'd127, 8'd100, 32'hDEADBEEF, 32'h0,        32'h0,        32'h11BB33DD};
        tbl[5] = '{1'b0, 8'd0,   32'h0,        4'h0,    8'd100, 8'd120, 32'hCAFEF00D, 32'h0,        32'h0,        32'h0};
        tbl[6] = '{1'b0, 8'd0,   32'h0,        4'h0,    8'd5,   8'd127, 32'h11BB33DD, 32'hDEADBEEF, 32'h0,        32'h0};
        tbl[7] = '{1'b0, 8'd0,   32'h0,        4'h0,    8'd0,   8'd0,   32'h0,        32'h0,        32'h11BB33DD, 32'h0};

        // Reset state
        #3;
        check("reset busy0", 64'(busy0), 64'(0));
        check("reset busy1", 64'(busy1), 64'(0));
        check("reset dump_valid", 64'(dv0), 64'(0));
        check("reset dump_last", 64'(dl0), 64'(0));
        check("reset reg rd_data", rd_data1, 64'(0));
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Clear with writes hammering every cycle
        clear_run(1'b0, 1'b1, c0, c1);
        check("clear busy cycles depth128", 64'(c0), 64'(128));
        check("clear busy cycles depth100", 64'(c1), 64'(100));
        for (int i = 0; i < 128; i++)
            rw_cycle(1'b0, 1'b0, 8'd0, 32'h0, 4'h0, 8'(i), 8'(127 - i), 1'b0, 0, 0, 0, 0, "readback");

        // Directed vectors: byte enables, read-first, ranges, registered latency
        foreach (tbl[i])
            rw_cycle(tbl[i].we, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].be, tbl[i].a0, tbl[i].a1,
                     1'b1, tbl[i].e0a, tbl[i].e0b, tbl[i].e1a, tbl[i].e1b, $sformatf("vec%0d", i));

        // Randomised traffic against the reference arrays
        for (int i = 0; i < 400; i++) begin
            wa = 8'($urandom_range(0, 140));
            a0 = ($urandom_range(0, 3) == 0) ? wa : 8'($urandom_range(0, 140));
            a1 = 8'($urandom_range(0, 140));
            rw_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), wa, $urandom,
                     4'($urandom_range(0, 15)), a0, a1, 1'b0, 0, 0, 0, 0, "random");
        end

        // Fill dut0 with mem[i] = i
        for (int i = 0; i < 128; i++)
            rw_cycle(1'b1, 1'b0, 8'(i), 32'(i), 4'hF, 8'(i), 8'd0, 1'b0, 0, 0, 0, 0, "fill");

        // Dump with 1-0-0-1 backpressure; a write on the start edge must be dropped
        wr_en = 1'b1; wr_adr = 8'd0; wr_data = 32'hFFFFFFFF; wr_be = 4'hF;
        dump_start = 1'b1; dump_ready = 1'b0;
        @(negedge clk);
        check("dump valid before start", 64'(dv0), 64'(0));
        @(posedge clk); #1;
        wr_en = 1'b0; dump_start = 1'b0;
        k = 0;
        for (int cyc = 0; cyc < 1000 && k < 128; cyc++) begin
            dump_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            @(negedge clk);
            check("dump valid", 64'(dv0), 64'(1));
            check("dump adr", 64'(da0), 64'(k));
            check("dump data", 64'(dd0), 64'(k));
            check("dump last", 64'(dl0), 64'(k == 127));
            check("dump busy", 64'(busy0), 64'(1));
            if (dv0 && dump_ready) k++;
            @(posedge clk); #1;
        end
        check("dump handshake count", 64'(k), 64'(128));
        @(negedge clk);
        check("dump done valid", 64'(dv0), 64'(0));
        check("dump done busy", 64'(busy0), 64'(0));
        @(posedge clk); #1;

        // Async reset mid-dump at word 40, then restart from address 0
        dump_ready = 1'b1; dump_start = 1'b1;
        @(posedge clk); #1;
        dump_start = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("mid dump adr", 64'(da0), 64'(40));
        rst_n = 1'b0;
        #1;
        check("mid reset valid", 64'(dv0), 64'(0));
        check("mid reset busy", 64'(busy0), 64'(0));
        check("mid reset last", 64'(dl0), 64'(0));
        check("mid reset reg rd_data", rd_data1, 64'(0));
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        dump_start = 1'b1;
        @(posedge clk); #1;
        dump_start = 1'b0;
        n = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            if (!dv0) break;
            check("restart adr", 64'(da0), 64'(n));
            check("restart data", 64'(dd0), 64'(n));
            check("restart last", 64'(dl0), 64'(n == 127));
            n++;
            @(posedge clk); #1;
        end
        check("restart word count", 64'(n), 64'(128));
        @(posedge clk); #1;

        // Simultaneous clear and dump start: clear wins
        clear_run(1'b1, 1'b0, c0, c1);
        check("clr+dump busy cycles", 64'(c0), 64'(128));
        for (int i = 0; i < 16; i++)
            rw_cycle(1'b0, 1'b0, 8'd0, 32'h0, 4'h0, 8'(i * 8), 8'(127 - i), 1'b0, 0, 0, 0, 0, "post clear");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
